// File: rtl/sdf_frame_scheduler.sv
// Frame scheduler that shares one SDF FFT/IFFT engine between an FFT and an IFFT requester.
// Round-robin grant per frame, sample load with handshake, drain wait, then tagged output stream.
module sdf_frame_scheduler #(
   parameter int NFFT      = 64,
   parameter int DRAIN_LAT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_fft,
   input  logic                      req_ifft,
   input  logic                      abort,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      gnt_fft,
   output logic                      gnt_ifft,
   output logic                      eng_start,
   output logic                      eng_inverse,
   output logic                      eng_en,
   output logic [$clog2(NFFT)-1:0]   sample_idx,
   output logic                      out_valid,
   output logic [$clog2(NFFT)-1:0]   out_idx,
   output logic                      out_last,
   output logic                      out_owner,
   output logic                      frame_done,
   output logic                      busy
);

   // state    | meaning
   // S_IDLE   | no frame in flight, arbitrating requests
   // S_LOAD   | accepting NFFT input samples from the owner
   // S_DRAIN  | engine flushing its pipeline, DRAIN_LAT cycles
   // S_OUTPUT | NFFT result samples leaving the engine

   localparam int IDXW = $clog2(NFFT);
   localparam int DLW  = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
   localparam int CNTW = (IDXW > DLW) ? IDXW : DLW;
   localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(NFFT - 1);
   localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(DRAIN_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_DRAIN  = 2'd2,
      S_OUTPUT = 2'd3
   } state_t;

   state_t          state, state_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            owner, owner_nx;
   logic            last_owner, last_owner_nx;
   logic            first_load, first_load_nx;
   logic            winner;
   logic            accept;

   // Owner encoding: 0 = FFT, 1 = IFFT. On a tie the requester that did not go last wins.
   assign winner = (req_fft && req_ifft) ? ~last_owner : req_ifft;
   assign accept = (state == S_LOAD) && in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         first_load <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         owner      <= owner_nx;
         last_owner <= last_owner_nx;
         first_load <= first_load_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      owner_nx      = owner;
      last_owner_nx = last_owner;
      first_load_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_fft || req_ifft) begin
               state_nx      = S_LOAD;
               cnt_nx        = '0;
               owner_nx      = winner;
               last_owner_nx = winner;
               first_load_nx = 1'b1;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (cnt == CNT_LAST) begin
                  state_nx = S_DRAIN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CNTW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               state_nx = S_OUTPUT;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNTW'(1);
            end
         end
         S_OUTPUT: begin
            if (cnt == CNT_LAST) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNTW'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
      // Abort overrides every in-frame transition; last_owner keeps the aborted owner.
      if (abort && (state != S_IDLE)) begin
         state_nx      = S_IDLE;
         cnt_nx        = '0;
         first_load_nx = 1'b0;
      end
   end

   always_comb begin
      in_ready    = 1'b0;
      gnt_fft     = 1'b0;
      gnt_ifft    = 1'b0;
      eng_start   = 1'b0;
      eng_inverse = 1'b0;
      eng_en      = 1'b0;
      sample_idx  = '0;
      out_valid   = 1'b0;
      out_idx     = '0;
      out_last    = 1'b0;
      out_owner   = 1'b0;
      frame_done  = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_LOAD: begin
            gnt_fft     = ~owner;
            gnt_ifft    = owner;
            eng_inverse = owner;
            in_ready    = 1'b1;
            eng_start   = first_load;
            eng_en      = accept;
            sample_idx  = cnt[IDXW-1:0];
         end
         S_DRAIN: begin
            gnt_fft     = ~owner;
            gnt_ifft    = owner;
            eng_inverse = owner;
            eng_en      = 1'b1;
         end
         S_OUTPUT: begin
            gnt_fft     = ~owner;
            gnt_ifft    = owner;
            eng_inverse = owner;
            eng_en      = 1'b1;
            out_valid   = 1'b1;
            out_idx     = cnt[IDXW-1:0];
            out_owner   = owner;
            out_last    = (cnt == CNT_LAST);
            frame_done  = (cnt == CNT_LAST);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_sdf_frame_scheduler.sv
// Directed bench for sdf_frame_scheduler (NFFT=64, DRAIN_LAT=8) with immediate assertions.
module tb_sdf_frame_scheduler;

   logic       clk;
   logic       rst;
   logic       req_fft;
   logic       req_ifft;
   logic       abort;
   logic       in_valid;
   logic       in_ready;
   logic       gnt_fft;
   logic       gnt_ifft;
   logic       eng_start;
   logic       eng_inverse;
   logic       eng_en;
   logic [5:0] sample_idx;
   logic       out_valid;
   logic [5:0] out_idx;
   logic       out_last;
   logic       out_owner;
   logic       frame_done;
   logic       busy;

   sdf_frame_scheduler #(.NFFT(64), .DRAIN_LAT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_fft     (req_fft),
      .req_ifft    (req_ifft),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .gnt_fft     (gnt_fft),
      .gnt_ifft    (gnt_ifft),
      .eng_start   (eng_start),
      .eng_inverse (eng_inverse),
      .eng_en      (eng_en),
      .sample_idx  (sample_idx),
      .out_valid   (out_valid),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .out_owner   (out_owner),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   int cyc;
   int t0;
   int prev_done;
   int n_acc, n_load, n_out, n_start, seq_err;
   int t_start, t_last, t_first, t_done;
   int n_ov, n_fd;

   function automatic logic [31:0] all_outs();
      return {13'd0, in_ready, gnt_fft, gnt_ifft, eng_start, eng_inverse, eng_en, sample_idx,
              out_valid, out_idx, out_last, out_owner, frame_done, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; inputs written after this apply to that cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Follows one frame cycle by cycle, gathering timing and per-cycle consistency errors.
   task automatic run_frame(input logic own, input int stall_mod, input int drop_at, input int budget);
      int k;
      k = 0;
      n_acc = 0; n_load = 0; n_out = 0; n_start = 0; seq_err = 0;
      t_start = -1; t_last = -1; t_first = -1; t_done = -1;
      for (int i = 0; i < budget; i++) begin
         next_cycle();
         abort = 1'b0;
         if (i == drop_at) begin
            req_fft  = 1'b0;
            req_ifft = 1'b0;
         end
         if (in_ready) begin
            k++;
            in_valid = (stall_mod == 0) || ((k % stall_mod) != 0);
         end else begin
            in_valid = 1'b1;
         end
         @(negedge clk);
         if (eng_start) begin
            n_start++;
            t_start = cyc;
         end
         if (in_ready) begin
            n_load++;
            if (eng_en !== in_valid) seq_err++;
            if (sample_idx !== n_acc[5:0]) seq_err++;
            if (in_valid) begin
               n_acc++;
               t_last = cyc;
            end
         end
         if (busy) begin
            if (gnt_fft !== ~own || gnt_ifft !== own || eng_inverse !== own) seq_err++;
            if (!in_ready && eng_en !== 1'b1) seq_err++;
         end else if ((gnt_fft | gnt_ifft | eng_inverse | eng_en | in_ready | out_valid) !== 1'b0) begin
            seq_err++;
         end
         if (out_valid) begin
            if (n_out == 0) t_first = cyc;
            if (out_idx !== n_out[5:0] || out_owner !== own || out_last !== (n_out == 63)) seq_err++;
            n_out++;
         end
         if (frame_done) begin
            t_done = cyc;
            if (out_last !== 1'b1) seq_err++;
            break;
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      rst = 1'b1; req_fft = 1'b0; req_ifft = 1'b0; abort = 1'b0; in_valid = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 32'd0);

      // 1: single FFT frame, in_valid constant
      next_cycle();
      req_fft = 1'b1; in_valid = 1'b1; t0 = cyc;
      run_frame(1'b0, 0, 0, 200);
      chk("t1_start", t_start, t0 + 1);
      chk("t1_nstart", n_start, 1);
      chk("t1_accepts", n_acc, 64);
      chk("t1_last_accept", t_last, t0 + 64);
      chk("t1_first_out", t_first, t0 + 73);
      chk("t1_done", t_done, t0 + 136);
      chk("t1_nout", n_out, 64);
      chk("t1_seq", seq_err, 0);
      next_cycle();
      @(negedge clk);
      chk("t1_idle_after", all_outs(), 32'd0);

      // 2: tie held for three frames after a fresh reset
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      req_fft = 1'b1; req_ifft = 1'b1; t0 = cyc;
      run_frame(1'b0, 0, -1, 200);
      chk("t2_f0_start", t_start, t0 + 1);
      chk("t2_f0_seq", seq_err, 0);
      chk("t2_f0_nout", n_out, 64);
      prev_done = t_done;
      run_frame(1'b1, 0, -1, 200);
      chk("t2_f1_gap", t_start - prev_done, 2);
      chk("t2_f1_seq", seq_err, 0);
      chk("t2_f1_nout", n_out, 64);
      prev_done = t_done;
      run_frame(1'b0, 0, 5, 200);
      chk("t2_f2_gap", t_start - prev_done, 2);
      chk("t2_f2_seq", seq_err, 0);
      chk("t2_f2_nout", n_out, 64);

      // 3: IFFT only, in_valid low on every 4th LOAD cycle
      next_cycle();
      req_ifft = 1'b1; t0 = cyc;
      run_frame(1'b1, 4, 0, 250);
      chk("t3_accepts", n_acc, 64);
      chk("t3_load_cycles", n_load, 85);
      chk("t3_last_accept", t_last, t0 + 85);
      chk("t3_first_out", t_first, t0 + 94);
      chk("t3_done", t_done, t0 + 157);
      chk("t3_seq", seq_err, 0);

      // 4: FFT frame aborted at DRAIN cnt=3, then a tie goes to IFFT
      next_cycle();
      req_fft = 1'b1; in_valid = 1'b1; t0 = cyc;
      n_ov = 0; n_fd = 0;
      for (int i = 1; i <= 80; i++) begin
         next_cycle();
         req_fft = 1'b0;
         abort = (i == 68);
         @(negedge clk);
         if (i == 68) begin
            chk("t4_in_drain_busy", busy, 1);
            chk("t4_in_drain_ready", in_ready, 0);
            chk("t4_in_drain_oval", out_valid, 0);
         end
         if (i == 69) begin
            chk("t4_abort_busy", busy, 0);
            chk("t4_abort_gnt", {gnt_fft, gnt_ifft}, 0);
         end
         if (i >= 69) begin
            if (out_valid) n_ov++;
            if (frame_done) n_fd++;
         end
      end
      chk("t4_no_out_valid", n_ov, 0);
      chk("t4_no_frame_done", n_fd, 0);
      next_cycle();
      req_fft = 1'b1; req_ifft = 1'b1; t0 = cyc;
      run_frame(1'b1, 0, 0, 200);
      chk("t4_tie_start", t_start, t0 + 1);
      chk("t4_tie_seq", seq_err, 0);
      chk("t4_tie_nout", n_out, 64);

      // 5: FFT frame, rst at out_idx=20, then a tie goes to FFT
      next_cycle();
      req_fft = 1'b1; in_valid = 1'b1; t0 = cyc;
      for (int i = 1; i <= 95; i++) begin
         next_cycle();
         req_fft = 1'b0;
         rst = (i == 93);
         @(negedge clk);
         if (i == 93) begin
            chk("t5_pre_rst_idx", out_idx, 20);
            chk("t5_pre_rst_oval", out_valid, 1);
         end
         if (i == 94) chk("t5_after_rst", all_outs(), 32'd0);
      end
      next_cycle();
      req_fft = 1'b1; req_ifft = 1'b1; t0 = cyc;
      run_frame(1'b0, 0, 0, 200);
      chk("t5_tie_start", t_start, t0 + 1);
      chk("t5_tie_seq", seq_err, 0);
      chk("t5_tie_nout", n_out, 64);

      // 6: IFFT request (with an IDLE abort) dropped mid-LOAD
      next_cycle();
      req_ifft = 1'b1; abort = 1'b1; t0 = cyc;
      run_frame(1'b1, 0, 20, 200);
      chk("t6_start", t_start, t0 + 1);
      chk("t6_done", t_done, t0 + 136);
      chk("t6_nout", n_out, 64);
      chk("t6_seq", seq_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
